// File: rtl/cpu_datapath_eae.sv
// PDP-8 accumulator datapath (AC, LK, MQ, IOT dataout) with an iterative
// multiply/divide engine and a debounced front-panel switch-register monitor.
module cpu_datapath_eae #(
    parameter int WIDTH     = 12,
    parameter int DT_WIDTH  = 8,
    parameter int SR_STABLE = 4
) (
    input  logic                clock,
    input  logic                resetN,
    input  logic                op_valid,
    input  logic [3:0]          ac_op,
    input  logic [WIDTH-1:0]    mb,
    input  logic [WIDTH-1:0]    swreg,
    input  logic [DT_WIDTH-1:0] datain,
    output logic [WIDTH-1:0]    ac,
    output logic                lk,
    output logic [WIDTH-1:0]    mq,
    output logic                busy,
    output logic                done,
    output logic [DT_WIDTH-1:0] dataout,
    output logic                srchange
);

    localparam int IT_W = $clog2(WIDTH);
    localparam int SC_W = $clog2(SR_STABLE + 1);
    localparam logic [IT_W-1:0] IT_LAST = IT_W'(WIDTH - 1);
    localparam logic [SC_W-1:0] SC_DONE = SC_W'(SR_STABLE);

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_CLA = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_TAD = 4'd3;
    localparam logic [3:0] OP_OSR = 4'd4;
    localparam logic [3:0] OP_LAS = 4'd5;
    localparam logic [3:0] OP_MQA = 4'd6;
    localparam logic [3:0] OP_SWP = 4'd7;
    localparam logic [3:0] OP_MQL = 4'd8;
    localparam logic [3:0] OP_CLL = 4'd9;
    localparam logic [3:0] OP_CML = 4'd10;
    localparam logic [3:0] OP_IOR = 4'd11;
    localparam logic [3:0] OP_IOW = 4'd12;
    localparam logic [3:0] OP_MUL = 4'd13;
    localparam logic [3:0] OP_DVI = 4'd14;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DVI
    } state_t;

    state_t state;

    // Engine working registers: opnd is the multiplicand or divisor,
    // {part_hi, part_lo} is the running product or {remainder, dividend/quotient}.
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] part_hi;
    logic [WIDTH-1:0] part_lo;
    logic [IT_W-1:0]  it_cnt;
    logic             last_iter;
    logic             accept;

    logic [WIDTH:0]   tad_sum;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_lo_nx;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] div_hi_nx;
    logic [WIDTH-1:0] div_lo_nx;

    logic [WIDTH-1:0] stable_sr;
    logic [WIDTH-1:0] cand_sr;
    logic [SC_W-1:0]  sr_cnt;
    logic [SC_W-1:0]  sr_cnt_nx;

    assign accept    = op_valid && !busy;
    assign last_iter = (it_cnt == IT_LAST);
    assign tad_sum   = {1'b0, ac} + {1'b0, mb};

    // Shift-add multiply: add multiplicand when the current multiplier bit is
    // set, then shift the whole {carry, hi, lo} right by one.
    assign mul_sum   = {1'b0, part_hi} + (part_lo[0] ? {1'b0, opnd} : '0);
    assign mul_lo_nx = {mul_sum[0], part_lo[WIDTH-1:1]};

    // Restoring divide: remainder < divisor always, so the difference fits WIDTH bits.
    assign div_shift = {part_hi, part_lo[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd});
    assign div_diff  = div_shift[WIDTH-1:0] - opnd;
    assign div_hi_nx = div_ge ? div_diff : div_shift[WIDTH-1:0];
    assign div_lo_nx = {part_lo[WIDTH-2:0], div_ge};

    always_ff @(posedge clock) begin
        if (state == S_IDLE) begin
            opnd    <= mb;
            part_hi <= (ac_op == OP_DVI) ? ac : '0;
            part_lo <= mq;
            it_cnt  <= '0;
        end else if (state == S_MUL) begin
            part_hi <= mul_sum[WIDTH:1];
            part_lo <= mul_lo_nx;
            it_cnt  <= it_cnt + 1'b1;
        end else begin
            part_hi <= div_hi_nx;
            part_lo <= div_lo_nx;
            it_cnt  <= it_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state   <= S_IDLE;
            ac      <= '0;
            lk      <= 1'b0;
            mq      <= '0;
            dataout <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        done <= 1'b1;
                        case (ac_op)
                            OP_NOP: ;
                            OP_CLA: ac <= '0;
                            OP_AND: ac <= ac & mb;
                            OP_TAD: begin
                                ac <= tad_sum[WIDTH-1:0];
                                lk <= lk ^ tad_sum[WIDTH];
                            end
                            OP_OSR: ac <= ac | swreg;
                            OP_LAS: ac <= swreg;
                            OP_MQA: ac <= ac | mq;
                            OP_SWP: begin
                                ac <= mq;
                                mq <= ac;
                            end
                            OP_MQL: begin
                                mq <= ac;
                                ac <= '0;
                            end
                            OP_CLL: lk <= 1'b0;
                            OP_CML: lk <= ~lk;
                            OP_IOR: ac <= ac | WIDTH'(datain);
                            OP_IOW: dataout <= ac[DT_WIDTH-1:0];
                            OP_MUL: begin
                                done  <= 1'b0;
                                busy  <= 1'b1;
                                state <= S_MUL;
                            end
                            OP_DVI: begin
                                // Quotient would not fit (or divide by zero): flag and finish now.
                                if (ac >= mb) begin
                                    lk <= 1'b1;
                                end else begin
                                    done  <= 1'b0;
                                    busy  <= 1'b1;
                                    state <= S_DVI;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    if (last_iter) begin
                        ac    <= mul_sum[WIDTH:1];
                        mq    <= mul_lo_nx;
                        lk    <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                S_DVI: begin
                    if (last_iter) begin
                        ac    <= div_hi_nx;
                        mq    <= div_lo_nx;
                        lk    <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign sr_cnt_nx = (swreg == cand_sr) ? sr_cnt + 1'b1 : SC_W'(1);

    // Switch register debounce: a new value must persist SR_STABLE cycles.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            stable_sr <= swreg;
            cand_sr   <= swreg;
            sr_cnt    <= '0;
            srchange  <= 1'b0;
        end else begin
            srchange <= 1'b0;
            if (swreg != stable_sr) begin
                cand_sr <= swreg;
                if (sr_cnt_nx == SC_DONE) begin
                    stable_sr <= swreg;
                    sr_cnt    <= '0;
                    srchange  <= 1'b1;
                end else begin
                    sr_cnt <= sr_cnt_nx;
                end
            end else begin
                sr_cnt <= '0;
            end
        end
    end

endmodule

// File: doc/cpu_datapath_eae.md
Name: cpu_datapath_eae

Overview:
- Parametrised accumulator datapath for the PDP-8 CPU: AC, LK, MQ, IOT dataout, and front-panel switch-register change detection.
- Adds an integrated iterative multiply/divide (EAE) engine with an op_valid/busy/done handshake, so MUL/DVI results no longer come from an external unit.
- The control FSM issues one operation per accepted op; word width and switch debounce are generics.

Parameters:
WIDTH, 12, data word width (AC, MQ, mb, swreg)
DT_WIDTH, 8, IOT data in/out width (must be <= WIDTH)
SR_STABLE, 4, consecutive cycles a new swreg value must hold before srchange pulses (>=1)

Ports:
clock  input  1  system clock, all state on rising edge
resetN  input  1  synchronous reset, active low
op_valid  input  1  operation request; accepted when op_valid && !busy
ac_op  input  4  operation code, sampled on accept
mb  input  WIDTH  memory buffer operand
swreg  input  WIDTH  front-panel switch register
datain  input  DT_WIDTH  IOT input data
ac  output  WIDTH  accumulator
lk  output  1  link bit
mq  output  WIDTH  multiplier-quotient register
busy  output  1  EAE operation in progress
done  output  1  one-cycle pulse: accepted op has completed
dataout  output  DT_WIDTH  IOT output register
srchange  output  1  one-cycle pulse on debounced swreg change

Behaviour:
- Reset (resetN=0 at an edge): ac=0, lk=0, mq=0, dataout=0, busy=0, done=0, srchange=0, FSM=IDLE, SR counter=0, stable_sr<=swreg. Reset wins over everything, including mid-MUL/DVI: the partial result is discarded and no done is issued.
- ac_op codes:
  - 0 NOP.
  - 1 CLA: ac=0.
  - 2 AND: ac&=mb.
  - 3 TAD: {c,ac}=ac+mb; lk^=c.
  - 4 OSR: ac|=swreg.
  - 5 LAS: ac=swreg.
  - 6 MQA: ac|=mq.
  - 7 SWP: ac<->mq.
  - 8 MQL: mq=ac, ac=0.
  - 9 CLL: lk=0.
  - 10 CML: lk=~lk.
  - 11 IOR: ac|=zero-extended datain.
  - 12 IOW: dataout=ac[DT_WIDTH-1:0].
  - 13 MUL.
  - 14 DVI.
  - 15 reserved, treated as NOP.
- Single-cycle ops (0-12, 15): registers update on the accepting edge; done=1 for the following cycle; busy stays 0.
- MUL (FSM IDLE->MUL->IDLE):
  - Accepting edge latches the multiplicand from mb and the multiplier from mq; busy=1.
  - Shift-add, one multiplier bit per cycle, exactly WIDTH iteration edges.
  - On the final edge: {ac,mq}=mq*mb (2*WIDTH-bit unsigned product, ac high), lk=0, busy=0, done=1 for one cycle.
  - Total: busy high for WIDTH cycles; done in cycle WIDTH+1 after accept.
- DVI (FSM IDLE->DVI->IDLE):
  - Dividend {ac,mq}, divisor mb, unsigned.
  - Overflow check on the accepting edge: if ac>=mb (includes mb=0), lk=1, ac/mq unchanged, no busy, done next cycle.
  - Otherwise busy=1 and restoring division runs WIDTH iterations. Final edge: mq=quotient, ac=remainder, lk=0, busy=0, done=1.
- ac/mq/lk hold their pre-op values while busy; intermediate state lives in internal registers.
- op_valid while busy is ignored (not queued). The upstream FSM must hold or reissue the request.
- An op presented on the same edge busy falls is ignored; it is accepted from the next edge.
- done and a new accept may coincide; done refers to the previous op.
- Arithmetic: all unsigned, modulo 2^WIDTH; TAD carry is bit WIDTH of the (WIDTH+1)-bit sum.
- swreg debounce:
  - If swreg!=stable_sr: compare with a candidate register. Same as candidate: counter++. Different: candidate=swreg, counter=1.
  - When counter reaches SR_STABLE: stable_sr=candidate, counter=0, srchange=1 for exactly one cycle.
  - If swreg returns to stable_sr before then: counter=0, no pulse.
  - Debounce runs independently of busy.

Test Plan:
- WIDTH=12. TAD with ac=0xFFF, mb=0x001, lk=0 -> ac=0x000, lk=1, done pulse one cycle later; AND with ac=0xF0F, mb=0x0FF -> ac=0x00F.
- MUL with mq=0x00A, mb=0x064 -> busy for 12 cycles, then ac=0x000, mq=0x3E8, lk=0, single done. MUL with mq=0xFFF, mb=0xFFF -> ac=0xFFE, mq=0x001.
- DVI with ac=0x001, mq=0x000, mb=0x003 -> mq=0x555, ac=0x001, lk=0 after 12 busy cycles. DVI with ac=0x005, mb=0x003 and with mb=0 -> lk=1, ac/mq unchanged, busy never asserted, done next cycle.
- Hold op_valid=1 with CLA during a MUL -> CLA ignored until busy falls. Assert resetN=0 at iteration 6 -> all outputs zero, no done, FSM IDLE.
- SR_STABLE=4: swreg 0x000->0x123 held 4 cycles -> exactly one srchange, on the 4th cycle. A 2-cycle glitch 0x000->0x7FF->0x000 -> no srchange. A change to 0x111 after 2 cycles -> count restarts.
- SWP with ac=0x123, mq=0x456 -> ac=0x456, mq=0x123. IOW with ac=0xABC -> dataout=0xBC. IOR with ac=0x100, datain=0x5A -> ac=0x15A.
